// File: rtl/panel_event_scheduler_if.sv
// Signal bundle between the panel front end and the event scheduler.
// The master drives button/frame/acknowledge inputs; the slave returns strobes and status.
interface panel_event_scheduler_if #(
    parameter int unsigned DEPTH = 4
);
    logic                     color_press;
    logic                     bright_press;
    logic                     frame_start;
    logic                     color_ready;
    logic                     clear_err;
    logic                     color_change;
    logic                     bright_change;
    logic                     busy;
    logic [$clog2(DEPTH):0]   pending;
    logic                     overflow;
    logic                     timeout_err;

    modport master (
        output color_press, bright_press, frame_start, color_ready, clear_err,
        input  color_change, bright_change, busy, pending, overflow, timeout_err
    );

    modport slave (
        input  color_press, bright_press, frame_start, color_ready, clear_err,
        output color_change, bright_change, busy, pending, overflow, timeout_err
    );
endinterface

// File: rtl/panel_event_scheduler.sv
// Queues colour/brightness button events and replays them as frame-aligned change strobes,
// with a colour acknowledge handshake, timeout and sticky error flags.
module panel_event_scheduler #(
    parameter int unsigned DEPTH    = 4,
    parameter int unsigned HOLD_MIN = 2,
    parameter int unsigned TIMEOUT  = 255
) (
    input logic                    clock,
    input logic                    reset_n,
    panel_event_scheduler_if.slave bus
);
    localparam int unsigned AW     = $clog2(DEPTH);
    localparam int unsigned PW     = AW + 1;
    localparam int unsigned CntMax = (HOLD_MIN > TIMEOUT) ? HOLD_MIN : TIMEOUT;
    localparam int unsigned CW     = $clog2(CntMax + 1);

    typedef enum logic [1:0] {StIdle, StWaitFrame, StAssert, StRelease} state_e;

    state_e          state_q, state_d;
    logic [DEPTH-1:0] mem_q;
    logic [AW-1:0]   wr_ptr_q, rd_ptr_q;
    logic [PW-1:0]   count_q, count_d, count_after_deq;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [CW:0]     elapsed;
    logic            type_q, type_d;
    logic            seen_q, seen_d;
    logic            color_change_q, bright_change_q;
    logic            overflow_q, timeout_q;
    logic            deq, color_acc, bright_acc, drop;
    logic            hold_done, ready_now, timeout_hit;

    // A pop in this cycle frees a slot for this cycle's pushes.
    always_comb begin
        deq             = (state_q == StWaitFrame) && bus.frame_start && (count_q != '0);
        count_after_deq = count_q - PW'(deq);
        color_acc       = bus.color_press && (count_after_deq < PW'(DEPTH));
        bright_acc      = bus.bright_press &&
                          ((count_after_deq + PW'(color_acc)) < PW'(DEPTH));
        drop            = (bus.color_press && !color_acc) || (bus.bright_press && !bright_acc);
        count_d         = count_after_deq + PW'(color_acc) + PW'(bright_acc);
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = '0;
        type_d      = type_q;
        seen_d      = seen_q;
        timeout_hit = 1'b0;
        elapsed     = {1'b0, cnt_q} + (CW + 1)'(1);
        hold_done   = elapsed >= (CW + 1)'(HOLD_MIN);
        ready_now   = seen_q || bus.color_ready;
        unique case (state_q)
            StIdle: begin
                if (count_q != '0) state_d = StWaitFrame;
            end
            StWaitFrame: begin
                if (deq) begin
                    state_d = StAssert;
                    type_d  = mem_q[rd_ptr_q];
                    seen_d  = 1'b0;
                end
            end
            StAssert: begin
                cnt_d = cnt_q + CW'(1);
                if (type_q) begin
                    if (hold_done) begin
                        state_d = StRelease;
                        cnt_d   = '0;
                    end
                end else begin
                    seen_d = ready_now;
                    if (ready_now && hold_done) begin
                        state_d = StRelease;
                        cnt_d   = '0;
                    end else if (!ready_now && (cnt_q == CW'(TIMEOUT - 1))) begin
                        state_d     = StRelease;
                        cnt_d       = '0;
                        timeout_hit = 1'b1;
                    end
                end
            end
            StRelease: begin
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == CW'(1)) begin
                    state_d = StIdle;
                    cnt_d   = '0;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state_q         <= StIdle;
            mem_q           <= '0;
            wr_ptr_q        <= '0;
            rd_ptr_q        <= '0;
            count_q         <= '0;
            cnt_q           <= '0;
            type_q          <= 1'b0;
            seen_q          <= 1'b0;
            color_change_q  <= 1'b0;
            bright_change_q <= 1'b0;
            overflow_q      <= 1'b0;
            timeout_q       <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            type_q   <= type_d;
            seen_q   <= seen_d;
            count_q  <= count_d;
            // Colour takes the first free slot, brightness the one after it.
            if (color_acc) mem_q[wr_ptr_q] <= 1'b0;
            if (bright_acc) mem_q[wr_ptr_q + AW'(color_acc)] <= 1'b1;
            wr_ptr_q        <= wr_ptr_q + AW'(color_acc) + AW'(bright_acc);
            rd_ptr_q        <= rd_ptr_q + AW'(deq);
            color_change_q  <= (state_d == StAssert) && !type_d;
            bright_change_q <= (state_d == StAssert) && type_d;
            overflow_q      <= drop || (overflow_q && !bus.clear_err);
            timeout_q       <= timeout_hit || (timeout_q && !bus.clear_err);
        end
    end

    assign bus.color_change  = color_change_q;
    assign bus.bright_change = bright_change_q;
    assign bus.busy          = (state_q != StIdle);
    assign bus.pending       = count_q;
    assign bus.overflow      = overflow_q;
    assign bus.timeout_err   = timeout_q;
endmodule

// File: tb/tb_panel_event_scheduler.sv
// Directed bench for panel_event_scheduler: a per-cycle vector table plus hand-written
// sequences for the timeout, partial-overflow and reset-during-strobe cases.
module tb_panel_event_scheduler;
    localparam int unsigned DEPTH = 4;

    logic clock = 1'b0;
    logic reset_n = 1'b0;
    int   n_checks = 0;
    int   n_fail = 0;

    always #5 clock = ~clock;

    panel_event_scheduler_if #(.DEPTH(DEPTH)) bus ();

    panel_event_scheduler #(
        .DEPTH   (DEPTH),
        .HOLD_MIN(2),
        .TIMEOUT (255)
    ) dut (
        .clock  (clock),
        .reset_n(reset_n),
        .bus    (bus)
    );

    typedef struct {
        logic cp, bp, fs, cr, ce;
        logic ec, eb, ebusy;
        int   epend;
        logic eovf;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic cp, bp, fs, cr, ce, ec, eb, ebusy, input int epend,
                       input logic eovf);
        vec_t v;
        v = '{cp: cp, bp: bp, fs: fs, cr: cr, ce: ce, ec: ec, eb: eb, ebusy: ebusy,
              epend: epend, eovf: eovf};
        vecs.push_back(v);
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic drive(input logic cp, bp, fs, cr, ce);
        bus.color_press  = cp;
        bus.bright_press = bp;
        bus.frame_start  = fs;
        bus.color_ready  = cr;
        bus.clear_err    = ce;
    endtask

    // Drive on the falling edge, sample 1 time unit after the rising edge.
    task automatic cycle(input logic cp, bp, fs, cr, ce);
        @(negedge clock);
        drive(cp, bp, fs, cr, ce);
        @(posedge clock);
        #1;
    endtask

    task automatic do_reset(input string tag);
        @(negedge clock);
        reset_n = 1'b0;
        drive(0, 0, 0, 0, 0);
        @(posedge clock);
        @(posedge clock);
        #1;
        check({tag, " rst cc"}, bus.color_change, 0);
        check({tag, " rst bc"}, bus.bright_change, 0);
        check({tag, " rst busy"}, bus.busy, 0);
        check({tag, " rst pend"}, bus.pending, 0);
        check({tag, " rst ovf"}, bus.overflow, 0);
        check({tag, " rst tmo"}, bus.timeout_err, 0);
        @(negedge clock);
        reset_n = 1'b1;
    endtask

    initial begin
        int hi;
        drive(0, 0, 0, 0, 0);

        //  cp bp fs cr ce | cc bc busy pend ovf
        // Single colour event, ready one cycle after the strobe rises.
        add(1, 0, 0, 0, 0,  0, 0, 0, 1, 0);
        add(0, 0, 0, 0, 0,  0, 0, 1, 1, 0);
        add(0, 0, 0, 0, 0,  0, 0, 1, 1, 0);
        add(0, 0, 1, 0, 0,  1, 0, 1, 0, 0);
        add(0, 0, 0, 1, 0,  1, 0, 1, 0, 0);
        add(0, 0, 0, 0, 0,  0, 0, 1, 0, 0);
        add(0, 0, 0, 0, 0,  0, 0, 1, 0, 0);
        add(0, 0, 0, 0, 0,  0, 0, 0, 0, 0);
        // Simultaneous presses: colour serviced first, then brightness.
        add(1, 1, 0, 0, 0,  0, 0, 0, 2, 0);
        add(0, 0, 0, 0, 0,  0, 0, 1, 2, 0);
        add(0, 0, 1, 0, 0,  1, 0, 1, 1, 0);
        add(0, 0, 0, 1, 0,  1, 0, 1, 1, 0);
        add(0, 0, 0, 0, 0,  0, 0, 1, 1, 0);
        add(0, 0, 0, 0, 0,  0, 0, 1, 1, 0);
        add(0, 0, 0, 0, 0,  0, 0, 0, 1, 0);
        add(0, 0, 0, 0, 0,  0, 0, 1, 1, 0);
        add(0, 0, 1, 0, 0,  0, 1, 1, 0, 0);
        add(0, 0, 0, 0, 0,  0, 1, 1, 0, 0);
        add(0, 0, 0, 0, 0,  0, 0, 1, 0, 0);
        add(0, 0, 0, 1, 0,  0, 0, 1, 0, 0);
        add(0, 0, 0, 0, 0,  0, 0, 0, 0, 0);
        // Ready pulses before ASSERT are ignored; ready arrives in the third ASSERT cycle.
        add(1, 0, 0, 0, 0,  0, 0, 0, 1, 0);
        add(0, 0, 0, 1, 0,  0, 0, 1, 1, 0);
        add(0, 0, 0, 1, 0,  0, 0, 1, 1, 0);
        add(0, 0, 1, 0, 0,  1, 0, 1, 0, 0);
        add(0, 0, 0, 0, 0,  1, 0, 1, 0, 0);
        add(0, 0, 0, 0, 0,  1, 0, 1, 0, 0);
        add(0, 0, 0, 1, 0,  0, 0, 1, 0, 0);
        add(0, 0, 0, 0, 0,  0, 0, 1, 0, 0);
        add(0, 0, 0, 0, 0,  0, 0, 0, 0, 0);
        // Six presses without frame_start, then sticky flag behaviour.
        add(1, 0, 0, 0, 0,  0, 0, 0, 1, 0);
        add(0, 1, 0, 0, 0,  0, 0, 1, 2, 0);
        add(1, 0, 0, 0, 0,  0, 0, 1, 3, 0);
        add(0, 1, 0, 0, 0,  0, 0, 1, 4, 0);
        add(1, 0, 0, 0, 0,  0, 0, 1, 4, 1);
        add(0, 1, 0, 0, 0,  0, 0, 1, 4, 1);
        add(0, 0, 0, 0, 1,  0, 0, 1, 4, 0);
        add(1, 1, 0, 0, 0,  0, 0, 1, 4, 1);
        add(1, 0, 0, 0, 1,  0, 0, 1, 4, 1);
        add(0, 0, 0, 0, 1,  0, 0, 1, 4, 0);
        // Pop and push in the same cycle on a full FIFO.
        add(0, 1, 1, 0, 0,  1, 0, 1, 4, 0);
        add(0, 0, 0, 1, 0,  1, 0, 1, 4, 0);
        add(0, 0, 0, 0, 0,  0, 0, 1, 4, 0);
        add(0, 0, 0, 0, 0,  0, 0, 1, 4, 0);
        add(0, 0, 0, 0, 0,  0, 0, 0, 4, 0);

        do_reset("init");

        for (int i = 0; i < vecs.size(); i++) begin
            cycle(vecs[i].cp, vecs[i].bp, vecs[i].fs, vecs[i].cr, vecs[i].ce);
            check($sformatf("vec%0d cc", i), bus.color_change, vecs[i].ec);
            check($sformatf("vec%0d bc", i), bus.bright_change, vecs[i].eb);
            check($sformatf("vec%0d busy", i), bus.busy, vecs[i].ebusy);
            check($sformatf("vec%0d pend", i), bus.pending, vecs[i].epend);
            check($sformatf("vec%0d ovf", i), bus.overflow, vecs[i].eovf);
            check($sformatf("vec%0d tmo", i), bus.timeout_err, 0);
        end

        // Colour acknowledge never arrives.
        do_reset("tmo");
        cycle(1, 0, 0, 0, 0);
        cycle(0, 0, 0, 0, 0);
        cycle(0, 0, 1, 0, 0);
        check("tmo strobe rise", bus.color_change, 1);
        hi = 1;
        for (int i = 0; i < 400; i++) begin
            cycle(0, 0, 0, 0, 0);
            if (bus.color_change !== 1'b1) break;
            hi++;
        end
        check("tmo strobe cycles", hi, 255);
        check("tmo flag", bus.timeout_err, 1);
        check("tmo release busy", bus.busy, 1);
        check("tmo release bc", bus.bright_change, 0);
        cycle(0, 0, 0, 0, 1);
        check("tmo clear", bus.timeout_err, 0);

        // Three entries queued, then a double press: one accepted, one dropped.
        do_reset("part");
        cycle(1, 0, 0, 0, 0);
        cycle(1, 0, 0, 0, 0);
        cycle(0, 1, 0, 0, 0);
        check("part pend3", bus.pending, 3);
        cycle(1, 1, 0, 0, 0);
        check("part pend4", bus.pending, 4);
        check("part ovf", bus.overflow, 1);

        // Reset one cycle into ASSERT, with a press on the reset edge.
        do_reset("mid");
        cycle(1, 0, 0, 0, 0);
        cycle(1, 0, 0, 0, 0);
        cycle(0, 0, 1, 0, 0);
        check("mid assert cc", bus.color_change, 1);
        check("mid assert pend", bus.pending, 1);
        @(negedge clock);
        reset_n = 1'b0;
        drive(1, 1, 0, 0, 0);
        @(posedge clock);
        #1;
        check("mid reset cc", bus.color_change, 0);
        check("mid reset pend", bus.pending, 0);
        check("mid reset busy", bus.busy, 0);
        @(negedge clock);
        reset_n = 1'b1;
        drive(0, 0, 0, 0, 0);
        for (int i = 0; i < 5; i++) begin
            cycle(0, 0, 1, 0, 0);
            check($sformatf("mid post%0d cc", i), bus.color_change, 0);
            check($sformatf("mid post%0d bc", i), bus.bright_change, 0);
            check($sformatf("mid post%0d busy", i), bus.busy, 0);
            check($sformatf("mid post%0d pend", i), bus.pending, 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/panel_event_scheduler.md
PANEL_EVENT_SCHEDULER -- requirements
Module: panel_event_scheduler

Interface
REQ-001 Parameter DEPTH, default 4: event FIFO entries; power of two, minimum 2.
REQ-002 Parameter HOLD_MIN, default 2: minimum cycles a change strobe is held high; minimum 1.
REQ-003 Parameter TIMEOUT, default 255: maximum cycles to wait for color_ready; minimum 1.
REQ-004 Ports: clock, in, 1, single clock; all logic SHALL be on its rising edge.
REQ-005 Ports: reset_n, in, 1, reset that is synchronous and active-low.
REQ-006 Ports: color_press, in, 1, one-cycle debounced colour-button pulse.
REQ-007 Ports: bright_press, in, 1, one-cycle debounced brightness-button pulse.
REQ-008 Ports: frame_start, in, 1, one-cycle pulse at the display frame boundary.
REQ-009 Ports: color_ready, in, 1, acknowledge pulse from the colour stepper.
REQ-010 Ports: clear_err, in, 1, clears the sticky error flags.
REQ-011 Ports: color_change, out, 1, change strobe to the colour stepper.
REQ-012 Ports: bright_change, out, 1, change strobe to the brightness divider.
REQ-013 Ports: busy, out, 1, high whenever the FSM is not in IDLE.
REQ-014 Ports: pending, out, $clog2(DEPTH)+1, current FIFO occupancy.
REQ-015 Ports: overflow, out, 1, sticky flag: an event was dropped.
REQ-016 Ports: timeout_err, out, 1, sticky flag: color_ready was never seen.

Function
REQ-017 Events SHALL be queued in a DEPTH-entry FIFO of 1-bit type: 0 = colour, 1 = brightness.
REQ-018 Enqueue order on simultaneous presses: colour is written first, then brightness (two entries in one cycle).
- If only one slot is free, colour is accepted, brightness is dropped, and overflow is set.
- If no slot is free, both events are dropped and overflow is set.
REQ-019 Occupancy update: a dequeue and enqueue(s) in the same cycle are both honoured; a dequeue frees a slot for that same cycle's enqueue; pending SHALL never exceed DEPTH.
REQ-020 FSM states: IDLE, WAIT_FRAME, ASSERT, RELEASE.
REQ-021 IDLE: if pending != 0, go to WAIT_FRAME on the next cycle.
REQ-022 WAIT_FRAME: on frame_start, pop the FIFO head, latch its type, and go to ASSERT; frame_start in any other state SHALL be ignored.
REQ-023 ASSERT: drive the strobe for the latched type high for every cycle in the state; the other strobe stays low.
REQ-024 ASSERT exit, colour: leave when color_ready has been seen high at least once AND at least HOLD_MIN cycles have elapsed.
REQ-025 ASSERT exit, brightness: leave after exactly HOLD_MIN cycles.
REQ-026 Colour timeout: if color_ready is not seen within TIMEOUT cycles of ASSERT entry, set timeout_err and go to RELEASE.
REQ-027 A color_ready pulse seen outside ASSERT-colour SHALL be ignored.
REQ-028 RELEASE: both strobes low for exactly 2 cycles, then IDLE, so the downstream edge detector re-arms.
REQ-029 Strobes SHALL be registered outputs and never high simultaneously.
REQ-030 Sticky flags: clear_err clears overflow and timeout_err; a set event in the same cycle wins over clear_err.

Reset
REQ-031 While reset_n is low at a clock edge, the block SHALL reset as follows:
- FSM returns to IDLE; FIFO is emptied.
- pending = 0; color_change = 0; bright_change = 0; busy = 0; overflow = 0; timeout_err = 0.
- Internal counters are cleared.
REQ-032 Reset mid-ASSERT SHALL drop the strobe low on that same edge, with no RELEASE phase.
REQ-033 Presses coinciding with a reset edge SHALL be discarded.

Verification
REQ-034 Colour press, frame_start 3 cycles later, color_ready 1 cycle after the strobe rises, with defaults -> color_change high for exactly 2 cycles, then low for 2 cycles, then busy = 0; pending goes 1 -> 0.
REQ-035 Simultaneous color_press and bright_press with an empty FIFO, then 2 frame_starts -> the colour strobe is serviced first, then the brightness strobe (high for HOLD_MIN cycles); overflow = 0.
REQ-036 Six single presses with no frame_start, DEPTH = 4 -> pending = 4 and overflow = 1; then clear_err -> overflow = 0.
REQ-037 Colour event with color_ready held low -> color_change high for 255 cycles, then timeout_err = 1 and RELEASE is entered.
REQ-038 Reset asserted 1 cycle into ASSERT -> strobes and pending = 0 on the next edge; a later frame_start produces no strobe.
